bg_text_line_fetcher: RTL and testbench

Sequences tile-map and character-data fetches for one text-mode background across one scanline. It walks the visible tiles left to right, reads each screen entry from VRAM, and resolves the character row address, applying flips, palette mode and charbase. It then reads the row's halfwords and emits 240 palette-indexed pixels, one per cycle, into the BG line buffer. It sits between the BG control registers and the shared VRAM read port.

---
 rtl/bg_text_line_fetcher.sv | 243 ++++++++++++++++++++++++
 tb/tb_bg_text_line_fetcher.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_text_line_fetcher.sv
// Text-mode BG scanline fetcher: walks visible tiles, reads map entries and
// character rows from VRAM, and streams SCREEN_W palette indices to the line buffer.
module bg_text_line_fetcher #(
  parameter int SCREEN_W = 240,
  parameter int MAX_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset_N,
  input  logic        start,
  input  logic [7:0]  line_y,
  input  logic [8:0]  scroll_x,
  input  logic [8:0]  scroll_y,
  input  logic [4:0]  screenbase,
  input  logic [1:0]  charbase,
  input  logic        palettemode,
  input  logic [1:0]  screensize,
  output logic        vram_req,
  output logic [15:0] vram_addr,
  input  logic        vram_ack,
  input  logic [15:0] vram_rdata,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_data,
  output logic        busy,
  output logic        line_done
);

  typedef enum logic [2:0] {S_IDLE, S_MAP, S_CHAR, S_EMIT, S_DONE} state_t;

  // MAX_WAIT is reserved: the handshake waits for vram_ack indefinitely.
  if (MAX_WAIT != 0) begin : g_max_wait_reserved
  end

  state_t      state_q, state_d;
  logic [5:0]  scx_q, scx_d;
  logic [2:0]  fx_q, fx_d;
  logic [8:0]  sy_q, sy_d;
  logic [4:0]  sbase_q, sbase_d;
  logic [1:0]  cbase_q, cbase_d;
  logic        pal_q, pal_d;
  logic [1:0]  size_q, size_d;
  logic [4:0]  tile_q, tile_d;
  logic [9:0]  name_q, name_d;
  logic        hflip_q, hflip_d;
  logic        vflip_q, vflip_d;
  logic [3:0]  palbank_q, palbank_d;
  logic [1:0]  k_q, k_d;
  logic [63:0] row_q, row_d;
  logic [2:0]  p_q, p_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vram_req_q, vram_req_d;
  logic [15:0] vram_addr_q, vram_addr_d;
  logic        pix_we_q, pix_we_d;
  logic [7:0]  pix_x_q, pix_x_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        busy_q, busy_d;
  logic        line_done_q, line_done_d;

  logic [5:0]  tx, ty;
  logic [1:0]  sbb;
  logic [15:0] map_addr, char_base;
  logic [2:0]  row_r, col;
  logic [3:0]  nib;
  logic [7:0]  pix_val;
  logic [1:0]  k_last;

  always_comb begin
    tx = scx_q + {1'b0, tile_q};
    ty = sy_q[8:3];
    case (size_q)
      2'd1:    sbb = {1'b0, tx[5]};
      2'd2:    sbb = {1'b0, ty[5]};
      2'd3:    sbb = {ty[5], tx[5]};
      default: sbb = 2'b00;
    endcase
    map_addr = {sbase_q, 11'd0} + {3'd0, sbb, 11'd0} + {5'd0, ty[4:0], tx[4:0], 1'b0};
    row_r = vflip_q ? ~sy_q[2:0] : sy_q[2:0];
    if (pal_q) char_base = {cbase_q, 14'd0} + {name_q, 6'd0} + {10'd0, row_r, 3'd0};
    else       char_base = {cbase_q, 14'd0} + {1'b0, name_q, 5'd0} + {11'd0, row_r, 2'd0};
    k_last = pal_q ? 2'd3 : 2'd1;
    col = hflip_q ? ~p_q : p_q;
    nib = row_q[{1'b0, col, 2'b00} +: 4];
    if (pal_q) pix_val = row_q[{col, 3'b000} +: 8];
    else       pix_val = (nib == 4'd0) ? 8'd0 : {palbank_q, nib};
  end

  always_comb begin
    state_d     = state_q;
    scx_d       = scx_q;
    fx_d        = fx_q;
    sy_d        = sy_q;
    sbase_d     = sbase_q;
    cbase_d     = cbase_q;
    pal_d       = pal_q;
    size_d      = size_q;
    tile_d      = tile_q;
    name_d      = name_q;
    hflip_d     = hflip_q;
    vflip_d     = vflip_q;
    palbank_d   = palbank_q;
    k_d         = k_q;
    row_d       = row_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    vram_req_d  = vram_req_q;
    vram_addr_d = vram_addr_q;
    pix_we_d    = 1'b0;
    pix_x_d     = pix_x_q;
    pix_data_d  = pix_data_q;
    busy_d      = busy_q;
    line_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // line_done_q is still high in the cycle after DONE, so a start there is dropped.
        if (start && !line_done_q) begin
          scx_d   = scroll_x[8:3];
          fx_d    = scroll_x[2:0];
          sy_d    = {1'b0, line_y} + scroll_y;
          sbase_d = screenbase;
          cbase_d = charbase;
          pal_d   = palettemode;
          size_d  = screensize;
          tile_d  = 5'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          state_d = S_MAP;
        end
      end
      S_MAP: begin
        if (!vram_req_q) begin
          vram_req_d  = 1'b1;
          vram_addr_d = map_addr;
        end else if (vram_ack) begin
          name_d     = vram_rdata[9:0];
          hflip_d    = vram_rdata[10];
          vflip_d    = vram_rdata[11];
          palbank_d  = vram_rdata[15:12];
          vram_req_d = 1'b0;
          k_d        = 2'd0;
          state_d    = S_CHAR;
        end
      end
      S_CHAR: begin
        if (!vram_req_q) begin
          vram_req_d  = 1'b1;
          vram_addr_d = char_base + {13'd0, k_q, 1'b0};
        end else if (vram_ack) begin
          row_d[{k_q, 4'b0000} +: 16] = vram_rdata;
          if (k_q == k_last) begin
            vram_req_d = 1'b0;
            p_d        = (tile_q == 5'd0) ? fx_q : 3'd0;
            state_d    = S_EMIT;
          end else begin
            k_d         = k_q + 2'd1;
            vram_addr_d = char_base + {13'd0, k_q + 2'd1, 1'b0};
          end
        end
      end
      S_EMIT: begin
        pix_we_d   = 1'b1;
        pix_x_d    = cnt_q;
        pix_data_d = pix_val;
        cnt_d      = cnt_q + 8'd1;
        p_d        = p_q + 3'd1;
        if (cnt_q == 8'(SCREEN_W - 1)) begin
          state_d = S_DONE;
        end else if (p_q == 3'd7) begin
          tile_d  = tile_q + 5'd1;
          state_d = S_MAP;
        end
      end
      S_DONE: begin
        line_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= S_IDLE;
      scx_q       <= '0;
      fx_q        <= '0;
      sy_q        <= '0;
      sbase_q     <= '0;
      cbase_q     <= '0;
      pal_q       <= 1'b0;
      size_q      <= '0;
      tile_q      <= '0;
      name_q      <= '0;
      hflip_q     <= 1'b0;
      vflip_q     <= 1'b0;
      palbank_q   <= '0;
      k_q         <= '0;
      row_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      vram_req_q  <= 1'b0;
      vram_addr_q <= '0;
      pix_we_q    <= 1'b0;
      pix_x_q     <= '0;
      pix_data_q  <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scx_q       <= scx_d;
      fx_q        <= fx_d;
      sy_q        <= sy_d;
      sbase_q     <= sbase_d;
      cbase_q     <= cbase_d;
      pal_q       <= pal_d;
      size_q      <= size_d;
      tile_q      <= tile_d;
      name_q      <= name_d;
      hflip_q     <= hflip_d;
      vflip_q     <= vflip_d;
      palbank_q   <= palbank_d;
      k_q         <= k_d;
      row_q       <= row_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      vram_req_q  <= vram_req_d;
      vram_addr_q <= vram_addr_d;
      pix_we_q    <= pix_we_d;
      pix_x_q     <= pix_x_d;
      pix_data_q  <= pix_data_d;
      busy_q      <= busy_d;
      line_done_q <= line_done_d;
    end
  end

  assign vram_req  = vram_req_q;
  assign vram_addr = vram_addr_q;
  assign pix_we    = pix_we_q;
  assign pix_x     = pix_x_q;
  assign pix_data  = pix_data_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;

endmodule

// File: tb/tb_bg_text_line_fetcher.sv
// Directed bench for bg_text_line_fetcher: vector table of whole-line runs plus
// hand-written handshake, start-filtering and reset sequences.
module tb_bg_text_line_fetcher;

  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  line_y = '0;
  logic [8:0]  scroll_x = '0;
  logic [8:0]  scroll_y = '0;
  logic [4:0]  screenbase = '0;
  logic [1:0]  charbase = '0;
  logic        palettemode = 1'b0;
  logic [1:0]  screensize = '0;
  logic        vram_req;
  logic [15:0] vram_addr;
  logic        vram_ack = 1'b0;
  logic [15:0] vram_rdata = '0;
  logic        pix_we;
  logic [7:0]  pix_x;
  logic [7:0]  pix_data;
  logic        busy;
  logic        line_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bg_text_line_fetcher #(.SCREEN_W(240), .MAX_WAIT(0)) dut (
    .clock(clock), .reset_N(reset_N), .start(start), .line_y(line_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .screenbase(screenbase),
    .charbase(charbase), .palettemode(palettemode), .screensize(screensize),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .pix_we(pix_we), .pix_x(pix_x),
    .pix_data(pix_data), .busy(busy), .line_done(line_done)
  );

  typedef struct {
    string       nm;
    logic [7:0]  ly;
    logic [8:0]  sx;
    logic [8:0]  sy;
    logic [4:0]  sb;
    logic [1:0]  cb;
    logic        pal;
    logic [1:0]  sz;
    logic [15:0] map_a;
    logic [15:0] map_a1;
    logic [15:0] last_map;
    logic [15:0] entry;
    logic [15:0] ch_a;
    logic [63:0] ch_data;
    logic [63:0] pix;
  } vec_t;

  logic [15:0] mem [int];
  logic [15:0] rd_log [$];
  logic [7:0]  pix_buf [240];
  logic [7:0]  ref_buf [240];
  int          pix_cnt = 0;
  int          xseq_err = 0;
  int          done_cnt = 0;
  int          stab_err = 0;
  int          wait_cnt = 0;
  bit          rand_delay = 1'b0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;

  // VRAM responder plus handshake-stability and pixel monitors, all at negedge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_N) begin
        prev_req = 1'b0;
      end else begin
        if (prev_req && !vram_ack && !(vram_req && vram_addr == prev_addr)) stab_err++;
        prev_req  = vram_req;
        prev_addr = vram_addr;
      end
      if (pix_we) begin
        if (pix_x != pix_cnt[7:0]) xseq_err++;
        if (pix_cnt < 240) pix_buf[pix_cnt] = pix_data;
        pix_cnt++;
      end
      if (line_done) done_cnt++;
      vram_ack = 1'b0;
      if (vram_req && reset_N) begin
        if (wait_cnt == 0) begin
          vram_ack   = 1'b1;
          vram_rdata = mem.exists(int'(vram_addr)) ? mem[int'(vram_addr)] : 16'h0000;
          rd_log.push_back(vram_addr);
          wait_cnt = rand_delay ? int'($urandom_range(0, 5)) : 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic loadVector(input vec_t v);
    line_y      = v.ly;
    scroll_x    = v.sx;
    scroll_y    = v.sy;
    screenbase  = v.sb;
    charbase    = v.cb;
    palettemode = v.pal;
    screensize  = v.sz;
    mem.delete();
    mem[int'(v.map_a)] = v.entry;
    for (int k = 0; k < 4; k++) mem[int'(v.ch_a) + 2 * k] = v.ch_data[16 * k +: 16];
  endtask

  task automatic clearLogs();
    rd_log.delete();
    pix_cnt  = 0;
    xseq_err = 0;
    done_cnt = 0;
    stab_err = 0;
    wait_cnt = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    loadVector(v);
    clearLogs();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput($sformatf("%s busy_after_start", v.nm), busy, 1);
    n = 0;
    while (!line_done && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkOutput($sformatf("%s line_done_seen", v.nm), line_done, 1);
    checkOutput($sformatf("%s busy_at_done", v.nm), busy, 0);
    repeat (3) @(negedge clock);
    checkOutput($sformatf("%s pixel_count", v.nm), pix_cnt, 240);
    checkOutput($sformatf("%s pix_x_sequence_errs", v.nm), xseq_err, 0);
    checkOutput($sformatf("%s line_done_pulses", v.nm), done_cnt, 1);
    checkOutput($sformatf("%s addr_stability_errs", v.nm), stab_err, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int nh, grp, ntiles, n, diffs;
    logic [63:0] got8;

    vecs[0] = '{"basic4bpp", 8'd0, 9'd0, 9'd0, 5'd0, 2'd1, 1'b0, 2'd0,
                16'h0000, 16'h0002, 16'h003A, 16'h1005, 16'h40A0,
                64'h0000_0000_0087_4321, 64'h0000_1817_1413_1211};
    vecs[1] = '{"hflip", 8'd0, 9'd0, 9'd0, 5'd0, 2'd1, 1'b0, 2'd0,
                16'h0000, 16'h0002, 16'h003A, 16'h1405, 16'h40A0,
                64'h0000_0000_0087_4321, 64'h1112_1314_1718_0000};
    vecs[2] = '{"vflip", 8'd1, 9'd0, 9'd0, 5'd0, 2'd1, 1'b0, 2'd0,
                16'h0000, 16'h0002, 16'h003A, 16'h0805, 16'h40B8,
                64'h0000_0000_0087_4321, 64'h0000_0807_0403_0201};
    vecs[3] = '{"wrap8bpp", 8'd0, 9'd504, 9'd0, 5'd0, 2'd0, 1'b1, 2'd1,
                16'h083E, 16'h0000, 16'h0038, 16'h0002, 16'h0080,
                64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211};
    vecs[4] = '{"size3_flips", 8'd10, 9'd0, 9'd250, 5'd3, 2'd2, 1'b0, 2'd3,
                16'h2800, 16'h2802, 16'h283A, 16'h2C07, 16'h80EC,
                64'h0000_0000_1B0C_F0A5, 64'h252A_002F_2C00_2B21};
    vecs[5] = '{"scroll3", 8'd0, 9'd3, 9'd0, 5'd0, 2'd1, 1'b0, 2'd0,
                16'h0000, 16'h0002, 16'h003C, 16'h1005, 16'h40A0,
                64'h0000_0000_0087_4321, 64'h0000_0000_0018_1714};

    #1;
    checkOutput("reset_outputs_zero",
                {vram_req, vram_addr, pix_we, pix_x, pix_data, busy, line_done}, 0);
    repeat (2) @(negedge clock);
    reset_N = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      nh     = vecs[i].pal ? 4 : 2;
      grp    = 1 + nh;
      ntiles = (vecs[i].sx[2:0] == 3'd0) ? 30 : 31;
      checkOutput($sformatf("%s vram_read_count", vecs[i].nm), rd_log.size(), grp * ntiles);
      if (rd_log.size() >= grp * ntiles) begin
        checkOutput($sformatf("%s first_map_addr", vecs[i].nm), rd_log[0], vecs[i].map_a);
        checkOutput($sformatf("%s second_map_addr", vecs[i].nm), rd_log[grp], vecs[i].map_a1);
        checkOutput($sformatf("%s last_map_addr", vecs[i].nm), rd_log[(ntiles - 1) * grp],
                    vecs[i].last_map);
        checkOutput($sformatf("%s first_char_addr", vecs[i].nm), rd_log[1], vecs[i].ch_a);
        checkOutput($sformatf("%s last_char_addr", vecs[i].nm), rd_log[nh],
                    vecs[i].ch_a + 16'(2 * (nh - 1)));
      end
      for (int j = 0; j < 8; j++) got8[8 * j +: 8] = pix_buf[j];
      checkOutput($sformatf("%s pixels_0_to_7", vecs[i].nm), got8, vecs[i].pix);
      if (i == 4) for (int j = 0; j < 240; j++) ref_buf[j] = pix_buf[j];
    end

    // Random ack latency must not change the emitted line.
    rand_delay = 1'b1;
    applyStimulus(vecs[4]);
    rand_delay = 1'b0;
    diffs = 0;
    for (int j = 0; j < 240; j++) if (pix_buf[j] !== ref_buf[j]) diffs++;
    checkOutput("rand_delay_pixel_diffs", diffs, 0);

    // A second start while busy is ignored; the one-line checks inside cover it.
    fork
      applyStimulus(vecs[0]);
      begin
        repeat (40) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    repeat (10) @(negedge clock);
    checkOutput("start_while_busy_no_restart", busy, 0);

    // Start coinciding with line_done is dropped.
    loadVector(vecs[0]);
    clearLogs();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!line_done && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("done_seq line_done_seen", line_done, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("start_on_done busy", busy, 0);
    checkOutput("start_on_done vram_req", vram_req, 0);

    // Asynchronous reset in the middle of pixel emission.
    loadVector(vecs[0]);
    clearLogs();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (pix_cnt < 20 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("mid_line pixels_reached", pix_cnt >= 20, 1);
    #2;
    reset_N = 1'b0;
    #1;
    checkOutput("mid_line_reset_outputs_zero",
                {vram_req, vram_addr, pix_we, pix_x, pix_data, busy, line_done}, 0);
    repeat (2) @(negedge clock);
    reset_N = 1'b1;
    @(negedge clock);
    applyStimulus(vecs[0]);
    for (int j = 0; j < 8; j++) got8[8 * j +: 8] = pix_buf[j];
    checkOutput("after_reset pixels_0_to_7", got8, vecs[0].pix);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
